// File: rtl/sdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdiv_pkg
// Description : Shared types and constants for the sequential signed divider.
//               Holds the controller state encoding, the saturation and
//               overflow constants at the default 32-bit dividend width, and
//               a helper that derives the iteration-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package sdiv_pkg;

    // Controller states, in the order a division walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Quotients returned for a zero divisor, chosen by the dividend sign.
    localparam logic [31:0] Q_POS_SAT    = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_NEG_SAT    = 32'h8000_0000;

    // The only dividend whose quotient can overflow, when divided by -1.
    localparam logic [31:0] MIN_DIVIDEND = 32'h8000_0000;

    // Width needed to count down from n-1 to 0.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(32);

endpackage : sdiv_pkg
`default_nettype wire

// File: rtl/sdiv_step.sv
`default_nettype none
// ============================================================================
// Module      : sdiv_step
// Description : One combinational restoring-division step. The next dividend
//               bit is shifted into the partial remainder and |divisor| is
//               trial-subtracted. A non-negative difference is kept and
//               produces quotient bit 1. Otherwise the shifted value is kept
//               and the quotient bit is 0.
// Ports       : rem_in      - partial remainder, W+1 bits, always < divisor_abs
//               bit_in      - next dividend bit, MSB first
//               divisor_abs - divisor magnitude, W+1 bits
//               rem_out     - next partial remainder
//               q_bit       - quotient bit for this step
// Revision    : 1.0 - initial release
// ============================================================================
module sdiv_step #(
    parameter int W = 16
) (
    input  logic [W:0] rem_in,
    input  logic       bit_in,
    input  logic [W:0] divisor_abs,
    output logic [W:0] rem_out,
    output logic       q_bit
);

    // The shifted value is one bit wider than the remainder. rem_in is below
    // divisor_abs <= 2^W, so the shifted value stays below 2^(W+1). The top
    // bit of the difference is then a valid borrow flag.
    logic [W+1:0] w_shifted;
    logic [W+1:0] w_diff;

    always_comb begin
        w_shifted = {rem_in, bit_in};
        w_diff    = w_shifted - {1'b0, divisor_abs};
        if (!w_diff[W+1]) begin
            rem_out = w_diff[W:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = w_shifted[W:0];
            q_bit   = 1'b0;
        end
    end

endmodule : sdiv_step
`default_nettype wire

// File: rtl/sdiv32_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : sdiv32_16_seq
// Description : Sequential signed divider. The dividend is N_DIVIDEND bits and
//               the divisor is N_DIVISOR bits. Results truncate toward zero.
//               One quotient bit is produced per cycle by restoring division.
//               Both sides use valid/ready handshakes, and the latency from
//               accept to out_valid is fixed at N_DIVIDEND+2 cycles.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, dividend, divisor       - operand side
//               out_valid/out_ready, quotient, remainder,
//               div_by_zero, overflow                      - result side
// Revision    : 1.0 - initial release
// ============================================================================
module sdiv32_16_seq
    import sdiv_pkg::*;
#(
    parameter int N_DIVIDEND = 32,
    parameter int N_DIVISOR  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_DIVIDEND-1:0] dividend,
    input  logic [N_DIVISOR-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_DIVIDEND-1:0] quotient,
    output logic [N_DIVISOR-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int                    C_CNT_W   = cnt_width(N_DIVIDEND);
    localparam logic [C_CNT_W-1:0]    C_CNT_TOP = C_CNT_W'(N_DIVIDEND - 1);
    localparam logic [N_DIVIDEND-1:0] C_Q_POS   = {1'b0, {(N_DIVIDEND-1){1'b1}}};
    localparam logic [N_DIVIDEND-1:0] C_Q_NEG   = {1'b1, {(N_DIVIDEND-1){1'b0}}};
    localparam logic [N_DIVIDEND-1:0] C_MIN_DD  = C_Q_NEG;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [N_DIVIDEND-1:0]   r_dividend;
    logic [N_DIVISOR-1:0]    r_divisor;
    logic                    r_sign_d;
    logic                    r_q_sign;
    logic [N_DIVISOR:0]      r_abs_divisor;
    logic [N_DIVISOR:0]      r_rem;
    // Holds the dividend magnitude at first. Each step shifts one bit out at
    // the top and one quotient bit in at the bottom. After the last step it
    // holds the quotient magnitude.
    logic [N_DIVIDEND-1:0]   r_work;
    logic [C_CNT_W-1:0]      r_cnt;

    logic [N_DIVIDEND-1:0]   w_abs_dividend;
    logic [N_DIVISOR:0]      w_divisor_ext;
    logic [N_DIVISOR:0]      w_abs_divisor;
    logic [N_DIVISOR:0]      w_step_rem;
    logic                    w_step_q;
    logic [N_DIVIDEND-1:0]   w_q_fix;
    logic [N_DIVISOR-1:0]    w_r_mag;
    logic [N_DIVISOR-1:0]    w_r_fix;
    logic                    w_div_zero;
    logic                    w_ovf;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = PREP;
                end
            end
            PREP: begin
                w_state_next = ITER;
            end
            ITER: begin
                // r_cnt == 0 marks the last of the N_DIVIDEND steps.
                if (r_cnt == '0) begin
                    w_state_next = FIXUP;
                end
            end
            FIXUP: begin
                w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning and result correction
    // ------------------------------------------------------------------
    always_comb begin
        // -2^(N-1) negates to itself. Read as unsigned, that is its correct
        // magnitude, so N bits are enough for the dividend.
        w_abs_dividend = r_dividend[N_DIVIDEND-1] ? -r_dividend : r_dividend;
        // The divisor is widened by one bit so that -2^(N_DIVISOR-1) has a
        // representable positive magnitude.
        w_divisor_ext  = {r_divisor[N_DIVISOR-1], r_divisor};
        w_abs_divisor  = r_divisor[N_DIVISOR-1] ? -w_divisor_ext : w_divisor_ext;

        w_q_fix        = r_q_sign ? -r_work : r_work;
        // The final partial remainder is below |divisor| <= 2^(N_DIVISOR-1),
        // so its top bit is always 0 here.
        w_r_mag        = r_rem[N_DIVISOR-1:0];
        w_r_fix        = r_sign_d ? -w_r_mag : w_r_mag;

        w_div_zero     = (r_divisor == '0);
        w_ovf          = (r_dividend == C_MIN_DD) && (r_divisor == '1);
    end

    sdiv_step #(
        .W (N_DIVISOR)
    ) u_step (
        .rem_in      (r_rem),
        .bit_in      (r_work[N_DIVIDEND-1]),
        .divisor_abs (r_abs_divisor),
        .rem_out     (w_step_rem),
        .q_bit       (w_step_q)
    );

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_sign_d      <= 1'b0;
            r_q_sign      <= 1'b0;
            r_abs_divisor <= '0;
            r_rem         <= '0;
            r_work        <= '0;
            r_cnt         <= '0;
            quotient      <= '0;
            remainder     <= '0;
            div_by_zero   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                    end
                end
                PREP: begin
                    r_sign_d      <= r_dividend[N_DIVIDEND-1];
                    r_q_sign      <= r_dividend[N_DIVIDEND-1] ^ r_divisor[N_DIVISOR-1];
                    r_work        <= w_abs_dividend;
                    r_abs_divisor <= w_abs_divisor;
                    r_rem         <= '0;
                    r_cnt         <= C_CNT_TOP;
                end
                ITER: begin
                    r_rem  <= w_step_rem;
                    r_work <= {r_work[N_DIVIDEND-2:0], w_step_q};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIXUP: begin
                    if (w_div_zero) begin
                        quotient    <= r_dividend[N_DIVIDEND-1] ? C_Q_NEG : C_Q_POS;
                        remainder   <= r_dividend[N_DIVISOR-1:0];
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else if (w_ovf) begin
                        quotient    <= C_Q_NEG;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                    end else begin
                        quotient    <= w_q_fix;
                        remainder   <= w_r_fix;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : sdiv32_16_seq
`default_nettype wire

// File: tb/tb_sdiv32_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdiv32_16_seq
// Description : Self-checking bench for sdiv32_16_seq. It applies a table of
//               directed vectors with hand-computed results and checks the
//               fixed latency. Extra sequences cover output backpressure with
//               a back-to-back accept, and a reset asserted mid-iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdiv32_16_seq;

    localparam int C_LAT = 34;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_total;
    int n_pass;

    typedef struct {
        logic [31:0] dd;
        logic [15:0] dv;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs[15];

    sdiv32_16_seq #(
        .N_DIVIDEND (32),
        .N_DIVISOR  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Counts edges after the accept edge until out_valid appears.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic do_op(input vec_t v, input string name);
        int cyc;
        @(negedge clk);
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = v.dd;
        divisor  = v.dv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // The divider must not depend on the operands after accept.
        dividend = $urandom;
        divisor  = 16'($urandom);
        wait_result(cyc);
        chk({name, " latency"},   32'(cyc),         32'(C_LAT));
        chk({name, " quotient"},  quotient,         v.q);
        chk({name, " remainder"}, 32'(remainder),   32'(v.r));
        chk({name, " flags"},     {30'd0, div_by_zero, overflow}, {30'd0, v.dz, v.ov});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, " idle after handshake"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int          cyc;
        logic [31:0] hold_q;
        logic        bp_ok;

        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        //            dividend      divisor   quotient      remainder dz    ov
        vecs[0]  = '{32'd1000,      16'd7,    32'h0000_008E, 16'h0006, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FC18, 16'd7,    32'hFFFF_FF72, 16'hFFFA, 1'b0, 1'b0};
        vecs[2]  = '{32'd1000,      16'hFFF9, 32'hFFFF_FF72, 16'h0006, 1'b0, 1'b0};
        vecs[3]  = '{32'hFFFF_FC18, 16'hFFF9, 32'h0000_008E, 16'hFFFA, 1'b0, 1'b0};
        vecs[4]  = '{32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'h0000, 1'b0, 1'b1};
        vecs[5]  = '{32'h8000_0000, 16'h8000, 32'h0001_0000, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{32'd12345,     16'd0,    32'h7FFF_FFFF, 16'h3039, 1'b1, 1'b0};
        vecs[7]  = '{32'hFFFF_FFFB, 16'd0,    32'h8000_0000, 16'hFFFB, 1'b1, 1'b0};
        vecs[8]  = '{32'h7FFF_FFFF, 16'h7FFF, 32'h0001_0002, 16'h0001, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0000, 16'd1,    32'h8000_0000, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{32'd7,         16'd1000, 32'h0000_0000, 16'h0007, 1'b0, 1'b0};
        vecs[11] = '{32'hFFFF_FFF9, 16'd1000, 32'h0000_0000, 16'hFFF9, 1'b0, 1'b0};
        vecs[12] = '{32'd0,         16'd5,    32'h0000_0000, 16'h0000, 1'b0, 1'b0};
        vecs[13] = '{32'h8000_0000, 16'h7FFF, 32'hFFFE_FFFE, 16'hFFFE, 1'b0, 1'b0};
        vecs[14] = '{32'hFFFF_FFFF, 16'hFFFF, 32'h0000_0001, 16'h0000, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {28'd0, in_ready, out_valid, div_by_zero, overflow}, 32'b1000);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, input ignored, then back-to-back accept
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(cyc);
        chk("bp latency", 32'(cyc), 32'(C_LAT));
        hold_q = quotient;
        bp_ok  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = (k == 4);
            dividend = 32'd99;
            divisor  = 16'd3;
            if (quotient !== 32'h8E || remainder !== 16'd6 || in_ready !== 1'b0 || out_valid !== 1'b1)
                bp_ok = 1'b0;
        end
        chk("bp hold stable", 32'(bp_ok), 32'd1);
        chk("bp quotient", hold_q, 32'h8E);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 32'd100;
        divisor   = 16'd9;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp handshake idle", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b accepted", 32'(in_ready), 32'd0);
        wait_result(cyc);
        chk("b2b latency", 32'(cyc), 32'(C_LAT));
        chk("b2b quotient", quotient, 32'd11);
        chk("b2b remainder", 32'(remainder), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during iteration
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd50000;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst flags", {28'd0, in_ready, out_valid, div_by_zero, overflow}, 32'b1000);
        chk("midrst quotient", quotient, 32'd0);
        chk("midrst remainder", 32'(remainder), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);
        do_op(vecs[0], "post-rst 1000/7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sdiv32_16_seq
`default_nettype wire
